// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key encoder: element and code constants,
// frame geometry and the keying FSM state type.
package morse_pkg;

    localparam int SEQ_W       = 10;
    localparam int FRAME_CHARS = 16;
    localparam int FRAME_W     = SEQ_W * FRAME_CHARS;
    localparam int ELEMS       = 5;

    localparam logic [1:0] ELEM_DOT   = 2'b00;
    localparam logic [1:0] ELEM_DASH  = 2'b01;
    localparam logic [1:0] ELEM_SPACE = 2'b10;
    localparam logic [1:0] ELEM_NONE  = 2'b11;

    localparam logic [SEQ_W-1:0] CODE_SPACE   = {ELEM_SPACE, {(ELEMS-1){ELEM_NONE}}};
    localparam logic [SEQ_W-1:0] CODE_INVALID = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_WORD
    } morse_state_t;

    // Element idx occupies the idx-th 2-bit field counting from the MSB end.
    function automatic logic [SEQ_W-1:0] put_elem(input logic [SEQ_W-1:0] code,
                                                  input logic [2:0]       idx,
                                                  input logic [1:0]       elem);
        logic [SEQ_W-1:0] r;
        r = code;
        for (int i = 0; i < ELEMS; i++) begin
            if (idx == 3'(i)) begin
                r[SEQ_W-1-2*i -: 2] = elem;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_key_debounce.sv
// Synchronises the raw telegraph key and accepts a new level only after it
// has been sampled DEBOUNCE_CYCLES times in a row.
module morse_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_db
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;

    // The run counter restarts whenever the synchronised level agrees with key_db,
    // so any glitch shorter than the debounce window never reaches key_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            key_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_key_encoder.sv
// Times debounced key presses, builds 10-bit Morse sequence codes and packs
// sixteen of them into a 160-bit frame handed over with a valid/ready handshake.
module morse_key_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key,
    input  logic               flush,
    output logic [FRAME_W-1:0] sequences,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [4:0]         char_count,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(7 * UNIT_CYCLES);
    localparam logic [4:0]       FULL     = 5'(FRAME_CHARS);

    logic             key_db;
    logic             key_db_q;
    logic             key_rise;
    logic             key_fall;
    logic [CNT_W-1:0] dur_cnt;

    morse_state_t     state;
    morse_state_t     next_state;
    logic             commit;
    logic [SEQ_W-1:0] commit_code;
    logic             store_elem;
    logic             store_dash;
    logic             clear_char;

    logic [SEQ_W-1:0] elems;
    logic [2:0]       elem_idx;
    logic             char_bad;

    logic [FRAME_W-1:0] acc;
    logic [FRAME_W-1:0] acc_next;
    logic [FRAME_W-1:0] seq_next;
    logic [4:0]         count_next;
    logic               valid_next;
    logic               ovf_next;
    logic               flush_pend;
    logic               flush_next;
    logic               flush_act;
    logic               emit;

    morse_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .key_db(key_db)
    );

    assign key_rise = key_db & ~key_db_q;
    assign key_fall = ~key_db & key_db_q;

    // dur_cnt restarts at 1 on each edge, so at the next edge it equals the
    // length of the level just ended, in cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_q <= 1'b0;
            dur_cnt  <= '0;
        end else begin
            key_db_q <= key_db;
            if (key_rise || key_fall) begin
                dur_cnt <= CNT_W'(1);
            end else if (dur_cnt != '1) begin
                dur_cnt <= dur_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A gap timeout and a new press can land in the same cycle; the commit
    // still happens and the new press is not lost.
    always_comb begin
        next_state  = state;
        commit      = 1'b0;
        commit_code = CODE_INVALID;
        store_elem  = 1'b0;
        store_dash  = 1'b0;
        clear_char  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_rise) next_state = ST_PRESS;
            end
            ST_PRESS: begin
                if (key_fall) begin
                    store_elem = 1'b1;
                    store_dash = (dur_cnt >= DASH_MIN);
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (dur_cnt == CHAR_GAP) begin
                    commit      = 1'b1;
                    commit_code = char_bad ? CODE_INVALID : elems;
                    clear_char  = 1'b1;
                    next_state  = key_rise ? ST_PRESS : ST_WORD;
                end else if (key_rise) begin
                    next_state = ST_PRESS;
                end
            end
            ST_WORD: begin
                if (dur_cnt == WORD_GAP) begin
                    commit      = 1'b1;
                    commit_code = CODE_SPACE;
                    next_state  = key_rise ? ST_PRESS : ST_IDLE;
                end else if (key_rise) begin
                    next_state = ST_PRESS;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elems    <= '1;
            elem_idx <= '0;
            char_bad <= 1'b0;
        end else if (clear_char) begin
            elems    <= '1;
            elem_idx <= '0;
            char_bad <= 1'b0;
        end else if (store_elem) begin
            if (elem_idx < 3'(ELEMS)) begin
                elems    <= put_elem(elems, elem_idx, store_dash ? ELEM_DASH : ELEM_DOT);
                elem_idx <= elem_idx + 1'b1;
            end else begin
                char_bad <= 1'b1;
            end
        end
    end

    assign flush_act = flush_pend && (state == ST_IDLE || state == ST_WORD);
    assign emit      = !frame_valid && ((char_count == FULL) || (flush_act && char_count != 5'd0));

    // An emit empties the accumulator first, so a commit in the same cycle
    // lands in slot 0 of the next frame instead of being dropped.
    always_comb begin
        acc_next   = acc;
        count_next = char_count;
        seq_next   = sequences;
        valid_next = frame_valid;
        ovf_next   = overflow;
        flush_next = flush_pend;
        if (frame_valid && frame_ready) begin
            valid_next = 1'b0;
        end
        if (emit) begin
            seq_next   = acc;
            valid_next = 1'b1;
            acc_next   = '1;
            count_next = 5'd0;
        end
        if (commit) begin
            if (count_next < FULL) begin
                for (int i = 0; i < FRAME_CHARS; i++) begin
                    if (count_next == 5'(i)) begin
                        acc_next[FRAME_W-1-SEQ_W*i -: SEQ_W] = commit_code;
                    end
                end
                count_next = count_next + 5'd1;
            end else begin
                ovf_next = 1'b1;
            end
        end
        if (flush) begin
            flush_next = 1'b1;
        end else if (flush_act && (char_count == 5'd0 || emit)) begin
            flush_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '1;
            char_count  <= 5'd0;
            sequences   <= '1;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            acc         <= acc_next;
            char_count  <= count_next;
            sequences   <= seq_next;
            frame_valid <= valid_next;
            overflow    <= ovf_next;
            flush_pend  <= flush_next;
        end
    end

endmodule

// File: tb/tb_morse_key_encoder.sv
// Self-checking bench for morse_key_encoder: table-driven character vectors,
// hand-written handshake/flush/reset sequences and a frame scoreboard.
module tb_morse_key_encoder;

    localparam int W = 160;

    typedef struct {
        string      name;
        int         n_elems;
        logic [5:0] dash_mask;
        logic [9:0] code;
    } char_vec_t;

    logic         clk;
    logic         rst_n;
    logic         key;
    logic         flush;
    logic [W-1:0] sequences;
    logic         frame_valid;
    logic         frame_ready;
    logic [4:0]   char_count;
    logic         overflow;

    int           pass_cnt;
    int           check_cnt;
    int           frames_seen;
    logic [W-1:0] exp_q[$];

    morse_key_encoder #(
        .UNIT_CYCLES    (4),
        .DEBOUNCE_CYCLES(2),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .flush      (flush),
        .sequences  (sequences),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .char_count (char_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        hold(2);
        rst_n = 1'b1;
        hold(2);
    endtask

    task automatic send_flush();
        flush = 1'b1;
        hold(1);
        flush = 1'b0;
    endtask

    // One character: dots are 4 cycles, dashes 12, 4-cycle gaps between elements.
    task automatic applyStimulus(input int n, input logic [5:0] mask, input int last_gap);
        for (int i = 0; i < n; i++) begin
            key = 1'b1;
            hold(mask[i] ? 12 : 4);
            key = 1'b0;
            hold((i == n - 1) ? last_gap : 4);
        end
    endtask

    task automatic send_e_chars(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, 6'b000000, 12);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            hold(1);
        end
        checkOutput(name, W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] make_frame(input logic [9:0] code, input int n);
        logic [W-1:0] f;
        f = '1;
        for (int i = 0; i < n; i++) begin
            f[W-1-10*i -: 10] = code;
        end
        return f;
    endfunction

    // Scoreboard: every accepted frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL unexpected frame: got %h, expected none", sequences);
            end else begin
                checkOutput("frame contents", sequences, exp_q.pop_front());
            end
        end
    end

    localparam logic [9:0] CODE_E  = 10'b0011111111;
    localparam logic [9:0] CODE_T  = 10'b0111111111;
    localparam logic [9:0] CODE_A  = 10'b0001111111;
    localparam logic [9:0] CODE_SP = 10'b1011111111;

    initial begin
        char_vec_t    vecs[7];
        logic [W-1:0] f;
        int           seen0;

        pass_cnt    = 0;
        check_cnt   = 0;
        frames_seen = 0;
        rst_n       = 1'b0;
        key         = 1'b0;
        flush       = 1'b0;
        frame_ready = 1'b1;

        vecs[0] = '{"A",           2, 6'b000010, 10'b0001111111};
        vecs[1] = '{"six dots",    6, 6'b000000, 10'b1111111111};
        vecs[2] = '{"five dots",   5, 6'b000000, 10'b0000000000};
        vecs[3] = '{"five dashes", 5, 6'b011111, 10'b0101010101};
        vecs[4] = '{"T",           1, 6'b000001, 10'b0111111111};
        vecs[5] = '{"K",           3, 6'b000101, 10'b0100011111};
        vecs[6] = '{"six mixed",   6, 6'b100000, 10'b1111111111};

        hold(3);
        checkOutput("reset sequences", sequences, '1);
        checkOutput("reset frame_valid", W'(frame_valid), W'(0));
        checkOutput("reset char_count", W'(char_count), W'(0));
        checkOutput("reset overflow", W'(overflow), W'(0));
        rst_n = 1'b1;
        hold(2);

        $display("[TB] character table");
        for (int i = 0; i < 7; i++) begin
            do_reset();
            applyStimulus(vecs[i].n_elems, vecs[i].dash_mask, 12);
            exp_q.push_back(make_frame(vecs[i].code, 1));
            send_flush();
            wait_drain({"drain ", vecs[i].name}, 100);
        end

        $display("[TB] A then word space then flush");
        do_reset();
        applyStimulus(1, 6'b000000, 4);
        applyStimulus(1, 6'b000001, 40);
        checkOutput("A+space char_count", W'(char_count), W'(2));
        f = '1;
        f[W-1 -: 10]  = CODE_A;
        f[W-11 -: 10] = CODE_SP;
        exp_q.push_back(f);
        send_flush();
        wait_drain("drain A+space", 100);
        hold(2);
        checkOutput("char_count after emit", W'(char_count), W'(0));

        $display("[TB] sixteen E with ready high");
        do_reset();
        seen0 = frames_seen;
        exp_q.push_back(make_frame(CODE_E, 16));
        send_e_chars(16);
        wait_drain("drain 16E", 100);
        checkOutput("single frame pulse", W'(frames_seen), W'(seen0 + 1));
        hold(40);
        checkOutput("one space after 16E", W'(char_count), W'(1));
        hold(100);
        checkOutput("long gap one space", W'(char_count), W'(1));

        $display("[TB] backpressure and overflow");
        do_reset();
        frame_ready = 1'b0;
        exp_q.push_back(make_frame(CODE_E, 16));
        exp_q.push_back(make_frame(CODE_E, 16));
        send_e_chars(16);
        hold(10);
        checkOutput("held frame_valid", W'(frame_valid), W'(1));
        checkOutput("held sequences", sequences, make_frame(CODE_E, 16));
        send_e_chars(16);
        hold(10);
        checkOutput("no overflow at 32", W'(overflow), W'(0));
        checkOutput("full at 32", W'(char_count), W'(16));
        send_e_chars(1);
        hold(10);
        checkOutput("overflow at 33", W'(overflow), W'(1));
        checkOutput("still held", sequences, make_frame(CODE_E, 16));
        frame_ready = 1'b1;
        wait_drain("drain two frames", 100);
        checkOutput("overflow sticky", W'(overflow), W'(1));
        do_reset();
        checkOutput("overflow cleared", W'(overflow), W'(0));

        $display("[TB] flush during press and empty flush");
        seen0 = frames_seen;
        key = 1'b1;
        hold(8);
        send_flush();
        hold(3);
        key = 1'b0;
        hold(8);
        checkOutput("no emit mid char", W'(frames_seen), W'(seen0));
        checkOutput("no valid mid char", W'(frame_valid), W'(0));
        exp_q.push_back(make_frame(CODE_T, 1));
        wait_drain("drain T", 100);
        send_flush();
        hold(10);
        checkOutput("empty flush no frame", W'(frames_seen), W'(seen0 + 1));
        hold(40);
        checkOutput("space after empty flush", W'(char_count), W'(1));
        checkOutput("still no frame", W'(frames_seen), W'(seen0 + 1));

        $display("[TB] asynchronous reset mid char with frame held");
        do_reset();
        frame_ready = 1'b0;
        applyStimulus(1, 6'b000000, 12);
        send_flush();
        hold(20);
        checkOutput("pre-reset valid", W'(frame_valid), W'(1));
        checkOutput("pre-reset frame", sequences, make_frame(CODE_E, 1));
        key = 1'b1;
        hold(6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async sequences", sequences, '1);
        checkOutput("async frame_valid", W'(frame_valid), W'(0));
        checkOutput("async char_count", W'(char_count), W'(0));
        checkOutput("async overflow", W'(overflow), W'(0));
        key = 1'b0;
        hold(2);
        rst_n = 1'b1;
        hold(2);
        frame_ready = 1'b1;
        applyStimulus(1, 6'b000001, 12);
        exp_q.push_back(make_frame(CODE_T, 1));
        send_flush();
        wait_drain("drain after reset", 100);

        hold(5);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
